// File: rtl/cdb_broadcaster_pkg.sv
// Shared definitions for the CDB broadcaster: None tag, payload field widths
// and the source encodings used on cdb_src.
package cdb_broadcaster_pkg;

    localparam int VAL_W    = 32;
    localparam int ADDR_W   = 32;
    localparam int NONE_TAG = 0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    // A FIFO of DEPTH entries needs one extra count bit to represent "full".
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cdb_broadcaster_result_fifo.sv
// Per-source result queue holding {tag, val, addr}; pauses on rdy_in low,
// clears on flush or reset.
module result_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PAY_W = 68,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             push,
    input  logic [PAY_W-1:0] push_data,
    input  logic             pop,
    output logic [PAY_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PAY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             step_ok;
    logic             push_ok;
    logic             pop_ok;

    assign step_ok = rst_in & rdy_in & ~flush;
    assign push_ok = step_ok & push & (count != CNT_W'(DEPTH));
    assign pop_ok  = step_ok & pop & (count != '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
                else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus driver: per-source result FIFOs with same-cycle bypass,
// a two-way round-robin arbiter and registered cdb_* outputs.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [VAL_W-1:0]  alu_val,
    input  logic [ADDR_W-1:0] alu_addr,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [VAL_W-1:0]  lsb_val,
    input  logic [ADDR_W-1:0] lsb_addr,
    output logic              lsb_ready,
    output logic              cdb_active,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [VAL_W-1:0]  cdb_val,
    output logic [ADDR_W-1:0] cdb_addr,
    output logic              cdb_src
);

    localparam int PAY_W = TAG_W + VAL_W + ADDR_W;
    localparam int CNT_W = cnt_width(DEPTH);

    logic [CNT_W-1:0] alu_cnt;
    logic [CNT_W-1:0] lsb_cnt;
    logic [PAY_W-1:0] alu_head;
    logic [PAY_W-1:0] lsb_head;

    logic             go_p0;
    logic             alu_live_p0;
    logic             lsb_live_p0;
    logic             alu_empty_p0;
    logic             lsb_empty_p0;
    logic             alu_cand_p0;
    logic             lsb_cand_p0;
    logic [PAY_W-1:0] alu_pay_p0;
    logic [PAY_W-1:0] lsb_pay_p0;
    logic [PAY_W-1:0] win_pay_p0;
    src_e             win_p0;
    logic             grant_p0;
    logic             alu_pop_p0;
    logic             lsb_pop_p0;
    logic             alu_push_p0;
    logic             lsb_push_p0;

    logic              vld_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [VAL_W-1:0]  val_p1;
    logic [ADDR_W-1:0] addr_p1;
    src_e              src_p1;
    src_e              last_grant_p1;

    // ---- stage p0: acceptance, candidate selection and arbitration ----
    assign go_p0     = rst_in & rdy_in & ~flush_in;
    assign alu_ready = rst_in & (alu_cnt < CNT_W'(DEPTH));
    assign lsb_ready = rst_in & (lsb_cnt < CNT_W'(DEPTH));

    // A transfer with the None tag is consumed here and never becomes live.
    assign alu_live_p0 = go_p0 & alu_valid & alu_ready & (alu_tag != TAG_W'(NONE_TAG));
    assign lsb_live_p0 = go_p0 & lsb_valid & lsb_ready & (lsb_tag != TAG_W'(NONE_TAG));

    assign alu_empty_p0 = (alu_cnt == '0);
    assign lsb_empty_p0 = (lsb_cnt == '0);
    assign alu_cand_p0  = ~alu_empty_p0 | alu_live_p0;
    assign lsb_cand_p0  = ~lsb_empty_p0 | lsb_live_p0;

    assign alu_pay_p0 = alu_empty_p0 ? {alu_tag, alu_val, alu_addr} : alu_head;
    assign lsb_pay_p0 = lsb_empty_p0 ? {lsb_tag, lsb_val, lsb_addr} : lsb_head;

    always_comb begin
        win_p0 = SRC_ALU;
        if (alu_cand_p0 && lsb_cand_p0)
            win_p0 = (last_grant_p1 == SRC_LSB) ? SRC_ALU : SRC_LSB;
        else if (lsb_cand_p0)
            win_p0 = SRC_LSB;
    end

    assign grant_p0   = go_p0 & (alu_cand_p0 | lsb_cand_p0);
    assign win_pay_p0 = (win_p0 == SRC_ALU) ? alu_pay_p0 : lsb_pay_p0;

    // A winning bypass skips its FIFO; a losing one (or one behind a head) queues.
    assign alu_pop_p0  = grant_p0 & (win_p0 == SRC_ALU) & ~alu_empty_p0;
    assign lsb_pop_p0  = grant_p0 & (win_p0 == SRC_LSB) & ~lsb_empty_p0;
    assign alu_push_p0 = alu_live_p0 & ~(grant_p0 & (win_p0 == SRC_ALU) & alu_empty_p0);
    assign lsb_push_p0 = lsb_live_p0 & ~(grant_p0 & (win_p0 == SRC_LSB) & lsb_empty_p0);

    result_fifo #(
        .DEPTH (DEPTH),
        .PAY_W (PAY_W),
        .CNT_W (CNT_W)
    ) u_alu_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush     (flush_in),
        .push      (alu_push_p0),
        .push_data ({alu_tag, alu_val, alu_addr}),
        .pop       (alu_pop_p0),
        .head      (alu_head),
        .count     (alu_cnt)
    );

    result_fifo #(
        .DEPTH (DEPTH),
        .PAY_W (PAY_W),
        .CNT_W (CNT_W)
    ) u_lsb_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush     (flush_in),
        .push      (lsb_push_p0),
        .push_data ({lsb_tag, lsb_val, lsb_addr}),
        .pop       (lsb_pop_p0),
        .head      (lsb_head),
        .count     (lsb_cnt)
    );

    // ---- stage p1: registered broadcast ----
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            vld_p1        <= 1'b0;
            tag_p1        <= '0;
            val_p1        <= '0;
            addr_p1       <= '0;
            src_p1        <= SRC_ALU;
            last_grant_p1 <= SRC_LSB;
        end else if (rdy_in) begin
            if (flush_in) begin
                vld_p1        <= 1'b0;
                last_grant_p1 <= SRC_LSB;
            end else if (grant_p0) begin
                vld_p1                    <= 1'b1;
                {tag_p1, val_p1, addr_p1} <= win_pay_p0;
                src_p1                    <= win_p0;
                last_grant_p1             <= win_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign cdb_active = vld_p1;
    assign cdb_tag    = tag_p1;
    assign cdb_val    = val_p1;
    assign cdb_addr   = addr_p1;
    assign cdb_src    = src_p1;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Testbench for cdb_broadcaster: table of hand-derived vectors, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_cdb_broadcaster;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        alu_valid, lsb_valid;
    logic [3:0]  alu_tag, lsb_tag;
    logic [31:0] alu_val, alu_addr, lsb_val, lsb_addr;
    logic        alu_ready, lsb_ready;
    logic        cdb_active, cdb_src;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val, cdb_addr;

    always #5 clk_in = ~clk_in;

    cdb_broadcaster #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val), .alu_addr(alu_addr),
        .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val), .lsb_addr(lsb_addr),
        .lsb_ready(lsb_ready),
        .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .cdb_addr(cdb_addr), .cdb_src(cdb_src)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [31:0] addr;
    } ent_t;

    typedef struct {
        bit         r, rdy, fl, av, lv;
        logic [3:0] at, lt;
        bit         e_ar, e_lr, e_act, e_src;
        logic [3:0] e_tag;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per source, winner picked by plain rules.
    ent_t        mq_a[$], mq_b[$];
    bit          m_lg, m_act, m_src, m_xa, m_xb;
    logic [3:0]  m_tag;
    logic [31:0] m_val, m_addr;

    bit          s_ar, s_lr;
    int          bc_count;
    logic [3:0]  lsb_seen[$];
    logic [3:0]  all_seen[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_step();
        bit   ra, rb, win;
        ent_t e;
        ra = rst_in && (mq_a.size() < DEPTH);
        rb = rst_in && (mq_b.size() < DEPTH);
        m_xa = 0;
        m_xb = 0;
        if (!rst_in) begin
            mq_a.delete(); mq_b.delete();
            m_act = 0; m_tag = 0; m_val = 0; m_addr = 0; m_src = 0; m_lg = 1;
            return;
        end
        if (!rdy_in) return;
        if (flush_in) begin
            mq_a.delete(); mq_b.delete();
            m_act = 0; m_lg = 1;
            return;
        end
        m_xa = alu_valid && ra;
        m_xb = lsb_valid && rb;
        if (m_xa && alu_tag != 0) mq_a.push_back('{alu_tag, alu_val, alu_addr});
        if (m_xb && lsb_tag != 0) mq_b.push_back('{lsb_tag, lsb_val, lsb_addr});
        if (mq_a.size() == 0 && mq_b.size() == 0) begin
            m_act = 0;
            return;
        end
        if (mq_a.size() > 0 && mq_b.size() > 0) win = m_lg ? 1'b0 : 1'b1;
        else                                    win = (mq_a.size() > 0) ? 1'b0 : 1'b1;
        e = win ? mq_b.pop_front() : mq_a.pop_front();
        m_act = 1; m_tag = e.tag; m_val = e.val; m_addr = e.addr; m_src = win; m_lg = win;
    endtask

    // One clock: readies sampled mid-cycle, outputs 1 time unit after the edge.
    task automatic step();
        #3;
        s_ar = alu_ready;
        s_lr = lsb_ready;
        chk("alu_ready", 64'(alu_ready), 64'(rst_in && (mq_a.size() < DEPTH)));
        chk("lsb_ready", 64'(lsb_ready), 64'(rst_in && (mq_b.size() < DEPTH)));
        model_step();
        @(posedge clk_in);
        #1;
        chk("cdb_active", 64'(cdb_active), 64'(m_act));
        chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        chk("cdb_val", 64'(cdb_val), 64'(m_val));
        chk("cdb_addr", 64'(cdb_addr), 64'(m_addr));
        chk("cdb_src", 64'(cdb_src), 64'(m_src));
        if (rst_in && rdy_in && cdb_active) begin
            bc_count++;
            all_seen.push_back(cdb_tag);
            if (cdb_src) lsb_seen.push_back(cdb_tag);
        end
    endtask

    function automatic logic [31:0] pval(input bit src, input logic [3:0] t);
        return (src ? 32'hB000_0000 : 32'hA000_0000) | 32'(t);
    endfunction
    function automatic logic [31:0] paddr(input bit src, input logic [3:0] t);
        return (src ? 32'h200 : 32'h100) * 32'(t);
    endfunction

    task automatic set_idle();
        rst_in = 1; rdy_in = 1; flush_in = 0;
        alu_valid = 0; lsb_valid = 0;
    endtask
    task automatic drive_alu(input logic [3:0] t);
        alu_valid = 1; alu_tag = t; alu_val = pval(0, t); alu_addr = paddr(0, t);
    endtask
    task automatic drive_lsb(input logic [3:0] t);
        lsb_valid = 1; lsb_tag = t; lsb_val = pval(1, t); lsb_addr = paddr(1, t);
    endtask

    function automatic vec_t mkv(input int r, rdy, fl, av, at, lv, lt,
                                 ear, elr, eact, etag, esrc);
        vec_t v;
        v.r = 1'(r); v.rdy = 1'(rdy); v.fl = 1'(fl);
        v.av = 1'(av); v.at = 4'(at); v.lv = 1'(lv); v.lt = 4'(lt);
        v.e_ar = 1'(ear); v.e_lr = 1'(elr); v.e_act = 1'(eact);
        v.e_tag = 4'(etag); v.e_src = 1'(esrc);
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        int next_l, full_offer, base;
        logic [3:0]  snap_tag;
        logic [31:0] snap_val;
        bit          snap_act, snap_src, old_seen;

        //           r rdy fl av at lv lt  ar lr act tag src
        vecs[0]  = mkv(0, 1, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0);
        vecs[1]  = mkv(0, 1, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 1, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
        vecs[4]  = mkv(1, 1, 0, 1, 2, 1, 5,  1, 1, 1, 2, 0);
        vecs[5]  = mkv(1, 1, 0, 1, 3, 1, 6,  1, 1, 1, 5, 1);
        vecs[6]  = mkv(1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 3, 0);
        vecs[7]  = mkv(1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 6, 1);
        vecs[8]  = mkv(1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 6, 1);
        vecs[9]  = mkv(1, 1, 0, 1, 0, 0, 0,  1, 1, 0, 6, 1);
        vecs[10] = mkv(1, 1, 0, 1, 3, 0, 0,  1, 1, 1, 3, 0);
        vecs[11] = mkv(1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 3, 0);

        alu_tag = 0; alu_val = 0; alu_addr = 0;
        lsb_tag = 0; lsb_val = 0; lsb_addr = 0;
        set_idle();
        rst_in = 0;

        for (int i = 0; i < 12; i++) begin
            rst_in = vecs[i].r; rdy_in = vecs[i].rdy; flush_in = vecs[i].fl;
            alu_valid = 0; lsb_valid = 0;
            if (vecs[i].av) drive_alu(vecs[i].at);
            if (vecs[i].lv) drive_lsb(vecs[i].lt);
            step();
            chk($sformatf("vec%0d_alu_ready", i), 64'(s_ar), 64'(vecs[i].e_ar));
            chk($sformatf("vec%0d_lsb_ready", i), 64'(s_lr), 64'(vecs[i].e_lr));
            chk($sformatf("vec%0d_active", i), 64'(cdb_active), 64'(vecs[i].e_act));
            chk($sformatf("vec%0d_tag", i), 64'(cdb_tag), 64'(vecs[i].e_tag));
            chk($sformatf("vec%0d_src", i), 64'(cdb_src), 64'(vecs[i].e_src));
            if (vecs[i].e_act) begin
                chk($sformatf("vec%0d_val", i), 64'(cdb_val), 64'(pval(vecs[i].e_src, vecs[i].e_tag)));
                chk($sformatf("vec%0d_addr", i), 64'(cdb_addr), 64'(paddr(vecs[i].e_src, vecs[i].e_tag)));
            end
        end

        // Single bypass with the literal payload.
        set_idle();
        alu_valid = 1; alu_tag = 1; alu_val = 32'h1234_5678; alu_addr = 32'h100;
        step();
        chk("bypass_active", 64'(cdb_active), 64'd1);
        chk("bypass_tag", 64'(cdb_tag), 64'd1);
        chk("bypass_val", 64'(cdb_val), 64'h1234_5678);
        chk("bypass_addr", 64'(cdb_addr), 64'h100);
        chk("bypass_src", 64'(cdb_src), 64'd0);
        set_idle();
        step();
        chk("bypass_done", 64'(cdb_active), 64'd0);

        // Backpressure: saturate both sources until the LSB FIFO fills.
        rst_in = 0; step();
        set_idle();
        lsb_seen.delete();
        next_l = 1;
        full_offer = 0;
        for (int k = 0; k < 24; k++) begin
            drive_alu(4'((k % 15) + 1));
            lsb_valid = 0;
            if (next_l <= 9) drive_lsb(4'(next_l));
            step();
            if (lsb_valid && !s_lr) full_offer++;
            if (m_xb) next_l++;
        end
        set_idle();
        for (int k = 0; k < 12; k++) step();
        chk("lsb_full_refused", 64'(full_offer > 0), 64'd1);
        chk("lsb_bcast_count", 64'(lsb_seen.size()), 64'd9);
        for (int i = 0; i < lsb_seen.size() && i < 9; i++)
            chk($sformatf("lsb_order%0d", i), 64'(lsb_seen[i]), 64'(i + 1));

        // Flush with three entries queued.
        drive_alu(10); drive_lsb(11); step();
        drive_alu(12); drive_lsb(13); step();
        drive_alu(14); drive_lsb(15); step();
        flush_in = 1; drive_alu(1); drive_lsb(2);
        step();
        chk("flush_active", 64'(cdb_active), 64'd0);
        set_idle();
        all_seen.delete();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_flush_idle%0d", k), 64'(cdb_active), 64'd0);
        end
        drive_alu(4); drive_lsb(5); step();
        chk("post_flush_tie_src", 64'(cdb_src), 64'd0);
        chk("post_flush_tie_tag", 64'(cdb_tag), 64'd4);
        set_idle(); step();
        old_seen = 0;
        foreach (all_seen[i]) if (all_seen[i] >= 12 || all_seen[i] == 1 || all_seen[i] == 2) old_seen = 1;
        chk("flush_no_old_tag", 64'(old_seen), 64'd0);

        // Pause for two cycles mid-stream.
        base = bc_count;
        drive_alu(1); drive_lsb(6); step();
        drive_alu(2); drive_lsb(7); step();
        drive_alu(3); drive_lsb(8); step();
        snap_act = cdb_active; snap_tag = cdb_tag; snap_val = cdb_val; snap_src = cdb_src;
        rdy_in = 0; drive_alu(9); drive_lsb(10);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("pause%0d_active", k), 64'(cdb_active), 64'(snap_act));
            chk($sformatf("pause%0d_tag", k), 64'(cdb_tag), 64'(snap_tag));
            chk($sformatf("pause%0d_val", k), 64'(cdb_val), 64'(snap_val));
            chk($sformatf("pause%0d_src", k), 64'(cdb_src), 64'(snap_src));
        end
        set_idle();
        for (int k = 0; k < 8; k++) step();
        chk("pause_bcast_count", 64'(bc_count - base), 64'd6);

        // Randomized traffic against the model.
        rst_in = 0; step();
        for (int k = 0; k < 800; k++) begin
            rst_in   = ($urandom_range(0, 99) != 0);
            rdy_in   = ($urandom_range(0, 99) < 85);
            flush_in = ($urandom_range(0, 99) < 3);
            alu_valid = ($urandom_range(0, 9) < 6);
            lsb_valid = ($urandom_range(0, 9) < 6);
            alu_tag = 4'($urandom_range(0, 15));
            lsb_tag = 4'($urandom_range(0, 15));
            alu_val = $urandom; alu_addr = $urandom;
            lsb_val = $urandom; lsb_addr = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
